// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
//   Front end for the SR latch. It takes two raw request lines (set and clear)
//   that are asynchronous and may bounce. It turns them into clean,
//   mutually exclusive s / r / control pulses for the latch.
//   The latch never sees s and r high together. Both s and r stay stable
//   for the whole time control is high.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   set_raw   in   raw set request (async, bouncy)
//   clr_raw   in   raw clear request (async, bouncy)
//   s         out  latch s input, registered
//   r         out  latch r input, registered
//   control   out  latch enable, registered, high PULSE_LEN cycles per command
//   busy      out  high while the sequencer is not idle
//   conflict  out  one-cycle pulse when arbitration drops a request
module sr_cmd_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3,
    parameter int unsigned PULSE_LEN       = 2,
    parameter bit          PRIO_SET        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic set_raw,
    input  logic clr_raw,
    output logic s,
    output logic r,
    output logic control,
    output logic busy,
    output logic conflict
);

    localparam int unsigned PCW = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0]   PCNT_LAST = PCW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP
    } state_t;

    // Channel 0 is set, channel 1 is clear.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_level;
    logic [1:0]       r_pend;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       w_rise;
    logic [1:0]       w_take;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PCW-1:0]   r_pcnt;

    logic             r_s;
    logic             r_r;
    logic             r_ctrl;
    logic             r_conflict;
    logic             w_s_nxt;
    logic             w_r_nxt;
    logic             w_ctrl_nxt;
    logic             w_conflict_nxt;
    logic             w_sel_set;

    assign w_raw = {clr_raw, set_raw};

    // The debounced level rises on the same edge that the pending flag is
    // set. This way the FSM can start the command on the very next edge.
    always_comb begin
        w_rise = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_rise[i] = r_sync2[i] & ~r_level[i] & (r_cnt[i] == CNT_LAST);
        end
    end

    // Synchronizers, debounce counters and pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_pend  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            // A fresh edge wins over consumption, so it is never lost.
            r_pend <= (r_pend & ~w_take) | w_rise;
        end
    end

    // State register. The outputs are also registered here, from the
    // next-output values that the output process computes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pcnt     <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_ctrl     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s_nxt;
            r_r        <= w_r_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_conflict <= w_conflict_nxt;
            if (r_state == ST_DRIVE) begin
                r_pcnt <= r_pcnt + 1'b1;
            end else begin
                r_pcnt <= '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|r_pend) w_state_nxt = ST_DRIVE;
            ST_DRIVE: if (r_pcnt == PCNT_LAST) w_state_nxt = ST_GAP;
            ST_GAP:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. It computes the values that the outputs will hold in the
    // next cycle. Both pending flags are consumed when a command launches.
    // The loser of a tie is dropped.
    always_comb begin
        w_s_nxt        = 1'b0;
        w_r_nxt        = 1'b0;
        w_ctrl_nxt     = 1'b0;
        w_conflict_nxt = 1'b0;
        w_take         = '0;
        w_sel_set      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_take = r_pend;
                    if (&r_pend) begin
                        w_conflict_nxt = 1'b1;
                        w_sel_set      = PRIO_SET;
                    end else begin
                        w_sel_set      = r_pend[0];
                    end
                    w_ctrl_nxt = 1'b1;
                    w_s_nxt    = w_sel_set;
                    w_r_nxt    = ~w_sel_set;
                end
            end
            ST_DRIVE: begin
                if (r_pcnt != PCNT_LAST) begin
                    w_s_nxt    = r_s;
                    w_r_nxt    = r_r;
                    w_ctrl_nxt = r_ctrl;
                end
            end
            default: begin
            end
        endcase
    end

    assign s        = r_s;
    assign r        = r_r;
    assign control  = r_ctrl;
    assign conflict = r_conflict;
    assign busy     = (r_state != ST_IDLE);

endmodule
